cdb_arbiter: RTL and testbench
==============================

CDB_ARBITER -- requirements
Module: cdb_arbiter

Interface
REQ-001 SHALL have parameter ISSUER, default 4, meaning the number of result requesters sharing the common data bus.
REQ-002 SHALL have parameter ROB_ENTRY, default 4, meaning the ROB depth; ROB_ENTRY_LOG2 = $clog2(ROB_ENTRY).
REQ-003 SHALL have parameter ARCH_ENTRY, default 32, meaning the architectural register count; ARCH_ENTRY_LOG2 = $clog2(ARCH_ENTRY).
REQ-004 SHALL have parameter DATA_WIDTH, default 32, meaning the result width.
REQ-005 SHALL have parameter MAX_WAIT, default 7, meaning the aging threshold in cycles, range 1..15.
REQ-006 SHALL have port CLK, input, 1 bit: the single clock; all state SHALL be on its rising edge.
REQ-007 SHALL have port RST, input, 1 bit: asynchronous, active-high reset.
REQ-008 SHALL have port cdb_isr_request, input, ISSUER bits: per-requester request; bit i belongs to requester i.
REQ-009 SHALL have port cdb_isr_data, input, ISSUER*DATA_WIDTH bits: per-requester result; slice i belongs to requester i.
REQ-010 SHALL have port cdb_isr_id, input, ISSUER*ROB_ENTRY_LOG2 bits: per-requester ROB tag.
REQ-011 SHALL have port cdb_isr_arch_id, input, ISSUER*ARCH_ENTRY_LOG2 bits: per-requester destination architectural register.
REQ-012 SHALL have port cdb_isr_grant, output, ISSUER bits: one-hot grant, combinational in the same cycle as the request.
REQ-013 SHALL have port cdb_stall, input, 1 bit: downstream backpressure.
REQ-014 SHALL have port cdb_valid, output, 1 bit: broadcast valid (registered).
REQ-015 SHALL have ports cdb_data (DATA_WIDTH), cdb_id (ROB_ENTRY_LOG2), cdb_arch_id (ARCH_ENTRY_LOG2) and cdb_src (ISSUER, one-hot), all outputs and registered, carrying the broadcast payload.

Function
REQ-016 SHALL hold a request until its grant is sampled; a request deasserted before grant SHALL simply be dropped, with no error.
REQ-017 SHALL assert at most one cdb_isr_grant bit per cycle, and only for a bit whose request is high.
REQ-018 SHALL assert no grant and hold all cdb_* outputs unchanged while cdb_stall=1.
REQ-019 SHALL select round-robin when no requester has aged: search starts at index rr_ptr, then rr_ptr+1, and wraps modulo ISSUER.
REQ-020 SHALL advance rr_ptr on a grant to (granted index + 1) mod ISSUER, wrapping from ISSUER-1 to 0; otherwise rr_ptr SHALL be held.
REQ-021 SHALL keep a per-requester wait counter (4 bits) that increments each cycle the requester's request=1 and it is not granted, saturating at MAX_WAIT.
REQ-022 SHALL clear a requester's wait counter when it is granted or when its request=0.
REQ-023 SHALL select the lowest-index aged requester (wait = MAX_WAIT), overriding round-robin; rr_ptr SHALL still update per REQ-020.
REQ-024 SHALL, on a grant in cycle N, register the granted slice into cdb_data, cdb_id and cdb_arch_id, set cdb_src to the grant and set cdb_valid=1 in cycle N+1 (latency 1).
REQ-025 SHALL drive cdb_valid=0 in cycle N+1 when there is no grant and no stall in cycle N, leaving the payload registers unchanged.
REQ-026 SHALL leave the wait counters unchanged during stall, so no aging accrues under backpressure.
REQ-027 SHALL grant requester 0 at cycle 0 after reset, since rr_ptr=0 and all counters are 0.

Reset
REQ-028 SHALL on RST=1, asynchronously and regardless of the clock, clear cdb_valid, cdb_data, cdb_id, cdb_arch_id, cdb_src, rr_ptr and all wait counters to 0.
REQ-029 SHALL force cdb_isr_grant=0 combinationally while RST=1.
REQ-030 SHALL discard a grant issued in the cycle reset asserts; its payload never appears on the bus.

Verification
REQ-031 Bench SHALL cover: after reset, all four requests high for 4 cycles -> grants 0001, 0010, 0100, 1000; cdb_valid=1 from cycle 1 with cdb_src matching the grant delayed one cycle.
REQ-032 Bench SHALL cover: only request[2] high with data 0xDEADBEEF, id 3, arch 5 -> grant 0100 in the same cycle; next cycle cdb_valid=1, cdb_data=0xDEADBEEF, cdb_id=3, cdb_arch_id=5, cdb_src=0100.
REQ-033 Bench SHALL cover: cdb_stall=1 for 3 cycles with requests pending -> grant=0, outputs frozen, wait counters frozen; after release arbitration resumes from the held rr_ptr.
REQ-034 Bench SHALL cover: MAX_WAIT=2 with request[3] held while a bench-modified rr_ptr sequence starves it -> a grant to index 3 no later than the cycle its counter reaches 2.
REQ-035 Bench SHALL cover: RST asserted mid-stream between clock edges -> cdb_valid=0 and grant=0 immediately; after release the first grant goes to the lowest-index requester.
REQ-036 Bench SHALL cover: request[1] dropped after 2 unserved cycles -> wait[1] reads 0 the next cycle and no grant ever goes to index 1.

Source files
------------

// File: rtl/cdb_arbiter_if.sv
// Common data bus request/broadcast bundle shared by result requesters and the arbiter.
// master = requester/consumer side, slave = arbiter side.
interface cdb_arbiter_if #(
  parameter int ISSUER     = 4,
  parameter int ROB_ENTRY  = 4,
  parameter int ARCH_ENTRY = 32,
  parameter int DATA_WIDTH = 32
);
  localparam int ROB_ENTRY_LOG2  = $clog2(ROB_ENTRY);
  localparam int ARCH_ENTRY_LOG2 = $clog2(ARCH_ENTRY);

  logic [ISSUER-1:0]                 cdb_isr_request;
  logic [ISSUER*DATA_WIDTH-1:0]      cdb_isr_data;
  logic [ISSUER*ROB_ENTRY_LOG2-1:0]  cdb_isr_id;
  logic [ISSUER*ARCH_ENTRY_LOG2-1:0] cdb_isr_arch_id;
  logic [ISSUER-1:0]                 cdb_isr_grant;
  logic                              cdb_stall;
  logic                              cdb_valid;
  logic [DATA_WIDTH-1:0]             cdb_data;
  logic [ROB_ENTRY_LOG2-1:0]         cdb_id;
  logic [ARCH_ENTRY_LOG2-1:0]        cdb_arch_id;
  logic [ISSUER-1:0]                 cdb_src;

  modport master (
    output cdb_isr_request, cdb_isr_data, cdb_isr_id, cdb_isr_arch_id, cdb_stall,
    input  cdb_isr_grant, cdb_valid, cdb_data, cdb_id, cdb_arch_id, cdb_src
  );

  modport slave (
    input  cdb_isr_request, cdb_isr_data, cdb_isr_id, cdb_isr_arch_id, cdb_stall,
    output cdb_isr_grant, cdb_valid, cdb_data, cdb_id, cdb_arch_id, cdb_src
  );
endinterface

// File: rtl/cdb_arbiter.sv
// Common data bus arbiter: round-robin grant with aging override, one-cycle
// registered broadcast of the granted result, frozen under downstream stall.
module cdb_arbiter #(
  parameter int ISSUER     = 4,
  parameter int ROB_ENTRY  = 4,
  parameter int ARCH_ENTRY = 32,
  parameter int DATA_WIDTH = 32,
  parameter int MAX_WAIT   = 7
) (
  input  logic            CLK,
  input  logic            RST,
  cdb_arbiter_if.slave    bus
);
  localparam int ROB_ENTRY_LOG2  = $clog2(ROB_ENTRY);
  localparam int ARCH_ENTRY_LOG2 = $clog2(ARCH_ENTRY);
  localparam int PTR_W           = (ISSUER > 1) ? $clog2(ISSUER) : 1;
  localparam logic [3:0]       WAIT_MAX = 4'(MAX_WAIT);
  localparam logic [PTR_W-1:0] LAST_IDX = PTR_W'(ISSUER - 1);

  logic [PTR_W-1:0]           rr_ptr;
  logic [PTR_W-1:0]           grant_idx;
  logic                       grant_any;
  logic [ISSUER-1:0]          grant;
  logic [3:0]                 wait_cnt [ISSUER];
  logic [DATA_WIDTH-1:0]      sel_data;
  logic [ROB_ENTRY_LOG2-1:0]  sel_id;
  logic [ARCH_ENTRY_LOG2-1:0] sel_arch;

  // Aged requesters win by lowest index; otherwise search from rr_ptr with wrap.
  always_comb begin
    logic [PTR_W-1:0] cand;
    grant_any = 1'b0;
    grant_idx = '0;
    grant     = '0;
    cand      = '0;
    if (!RST && !bus.cdb_stall) begin
      for (int unsigned i = 0; i < ISSUER; i++) begin
        if (!grant_any && bus.cdb_isr_request[i] && wait_cnt[i] == WAIT_MAX) begin
          grant_any = 1'b1;
          grant_idx = PTR_W'(i);
        end
      end
      for (int unsigned k = 0; k < ISSUER; k++) begin
        cand = PTR_W'((32'(rr_ptr) + k) % ISSUER);
        if (!grant_any && bus.cdb_isr_request[cand]) begin
          grant_any = 1'b1;
          grant_idx = cand;
        end
      end
      if (grant_any) grant[grant_idx] = 1'b1;
    end
  end

  assign bus.cdb_isr_grant = grant;

  always_comb begin
    sel_data = '0;
    sel_id   = '0;
    sel_arch = '0;
    for (int unsigned i = 0; i < ISSUER; i++) begin
      if (grant[i]) begin
        sel_data = bus.cdb_isr_data[i*DATA_WIDTH +: DATA_WIDTH];
        sel_id   = bus.cdb_isr_id[i*ROB_ENTRY_LOG2 +: ROB_ENTRY_LOG2];
        sel_arch = bus.cdb_isr_arch_id[i*ARCH_ENTRY_LOG2 +: ARCH_ENTRY_LOG2];
      end
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      bus.cdb_valid   <= 1'b0;
      bus.cdb_data    <= '0;
      bus.cdb_id      <= '0;
      bus.cdb_arch_id <= '0;
      bus.cdb_src     <= '0;
      rr_ptr          <= '0;
      for (int unsigned i = 0; i < ISSUER; i++) wait_cnt[i] <= '0;
    end else if (!bus.cdb_stall) begin
      bus.cdb_valid <= grant_any;
      if (grant_any) begin
        bus.cdb_data    <= sel_data;
        bus.cdb_id      <= sel_id;
        bus.cdb_arch_id <= sel_arch;
        bus.cdb_src     <= grant;
        rr_ptr          <= (grant_idx == LAST_IDX) ? '0 : grant_idx + 1'b1;
      end
      for (int unsigned i = 0; i < ISSUER; i++) begin
        if (!bus.cdb_isr_request[i] || grant[i])
          wait_cnt[i] <= '0;
        else if (wait_cnt[i] < WAIT_MAX)
          wait_cnt[i] <= wait_cnt[i] + 4'd1;
      end
    end
  end
endmodule

// File: tb/tb_cdb_arbiter.sv
// Scoreboard bench for cdb_arbiter: directed request patterns, stall, async
// reset mid-stream, request drop, and an aging instance with MAX_WAIT=2.
module tb_cdb_arbiter;
  typedef struct packed {
    logic        valid;
    logic [31:0] data;
    logic [1:0]  id;
    logic [4:0]  arch;
    logic [3:0]  src;
  } sb_item_t;

  logic CLK = 1'b0;
  logic RST = 1'b0;
  int   n_tests = 0;
  int   n_fail  = 0;

  logic [31:0] pdata [4];
  logic [1:0]  pid   [4];
  logic [4:0]  parch [4];
  sb_item_t    exp_q [$];

  cdb_arbiter_if #(.ISSUER(4), .ROB_ENTRY(4), .ARCH_ENTRY(32), .DATA_WIDTH(32)) bus ();
  cdb_arbiter_if #(.ISSUER(4), .ROB_ENTRY(4), .ARCH_ENTRY(32), .DATA_WIDTH(32)) bus_a ();

  cdb_arbiter #(.ISSUER(4), .ROB_ENTRY(4), .ARCH_ENTRY(32), .DATA_WIDTH(32), .MAX_WAIT(7)) dut (
    .CLK(CLK), .RST(RST), .bus(bus)
  );
  cdb_arbiter #(.ISSUER(4), .ROB_ENTRY(4), .ARCH_ENTRY(32), .DATA_WIDTH(32), .MAX_WAIT(2)) dut_a (
    .CLK(CLK), .RST(RST), .bus(bus_a)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic apply_payload();
    for (int i = 0; i < 4; i++) begin
      bus.cdb_isr_data[i*32 +: 32]  = pdata[i];
      bus.cdb_isr_id[i*2 +: 2]      = pid[i];
      bus.cdb_isr_arch_id[i*5 +: 5] = parch[i];
    end
  endtask

  // Drives one cycle from a negedge, checks the same-cycle grant, queues the
  // broadcast expected after the next rising edge, returns at the next negedge.
  task automatic cycle(input logic [3:0] req, input logic stall, input logic [3:0] exp_g,
                       input logic [3:0] req_a, input logic [3:0] exp_ga);
    sb_item_t it;
    int idx;
    apply_payload();
    bus.cdb_isr_request   = req;
    bus.cdb_stall         = stall;
    bus_a.cdb_isr_request = req_a;
    bus_a.cdb_stall       = 1'b0;
    #1;
    check("grant", 32'(bus.cdb_isr_grant), 32'(exp_g));
    if (req_a != 4'b0000) check("grant_aging", 32'(bus_a.cdb_isr_grant), 32'(exp_ga));
    if (!stall) begin
      idx = 0;
      for (int i = 0; i < 4; i++) if (exp_g[i]) idx = i;
      it.valid = (exp_g != 4'b0000);
      it.data  = pdata[idx];
      it.id    = pid[idx];
      it.arch  = parch[idx];
      it.src   = exp_g;
      exp_q.push_back(it);
    end
    @(negedge CLK);
  endtask

  // Monitor: every rising edge taken out of reset and stall produces one broadcast decision.
  initial begin
    sb_item_t e;
    logic st, r;
    forever begin
      @(posedge CLK);
      st = bus.cdb_stall;
      r  = RST;
      #1;
      if (!r && !st) begin
        n_tests++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL sb_underflow: unexpected broadcast slot valid=%b at %0t", bus.cdb_valid, $time);
        end else begin
          e = exp_q.pop_front();
          if (bus.cdb_valid !== e.valid ||
              (e.valid && ({bus.cdb_data, bus.cdb_id, bus.cdb_arch_id, bus.cdb_src} !==
                           {e.data, e.id, e.arch, e.src}))) begin
            n_fail++;
            $display("FAIL broadcast: got v=%b d=%h id=%h arch=%h src=%b expected v=%b d=%h id=%h arch=%h src=%b at %0t",
                     bus.cdb_valid, bus.cdb_data, bus.cdb_id, bus.cdb_arch_id, bus.cdb_src,
                     e.valid, e.data, e.id, e.arch, e.src, $time);
          end
        end
      end
    end
  end

  initial begin
    #50000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
    $fatal(1, "timeout");
  end

  initial begin
    for (int i = 0; i < 4; i++) begin
      pdata[i] = 32'hA5A5_0000 + 32'(i * 17);
      pid[i]   = 2'(i);
      parch[i] = 5'(i + 8);
    end
    bus.cdb_isr_request   = 4'b1111;
    bus.cdb_stall         = 1'b0;
    bus_a.cdb_isr_request = 4'b0000;
    bus_a.cdb_isr_data    = '0;
    bus_a.cdb_isr_id      = '0;
    bus_a.cdb_isr_arch_id = '0;
    bus_a.cdb_stall       = 1'b0;
    apply_payload();

    // Reset asserted before any clock edge must act at once.
    #2 RST = 1'b1;
    #1;
    check("rst_grant", 32'(bus.cdb_isr_grant), 32'h0);
    check("rst_valid", 32'(bus.cdb_valid), 32'h0);
    check("rst_src",   32'(bus.cdb_src), 32'h0);
    check("rst_data",  bus.cdb_data, 32'h0);
    @(negedge CLK);
    @(negedge CLK);
    RST = 1'b0;

    // All four requesting: plain rotation from index 0.
    cycle(4'b1111, 1'b0, 4'b0001, 4'b0000, 4'b0000);
    cycle(4'b1111, 1'b0, 4'b0010, 4'b0000, 4'b0000);
    cycle(4'b1111, 1'b0, 4'b0100, 4'b0000, 4'b0000);
    cycle(4'b1111, 1'b0, 4'b1000, 4'b0000, 4'b0000);

    // Single requester with a distinctive payload.
    pdata[2] = 32'hDEAD_BEEF;
    pid[2]   = 2'd3;
    parch[2] = 5'd5;
    cycle(4'b0100, 1'b0, 4'b0100, 4'b0000, 4'b0000);
    check("single_data", bus.cdb_data, 32'hDEAD_BEEF);
    check("single_id",   32'(bus.cdb_id), 32'd3);
    check("single_arch", 32'(bus.cdb_arch_id), 32'd5);
    check("single_src",  32'(bus.cdb_src), 32'b0100);
    cycle(4'b0000, 1'b0, 4'b0000, 4'b0000, 4'b0000);

    // Stall: rr_ptr sits at 3, so the pre-stall grant goes to 3 and the next to 0.
    cycle(4'b1111, 1'b0, 4'b1000, 4'b0000, 4'b0000);
    for (int s = 0; s < 3; s++) begin
      cycle(4'b1111, 1'b1, 4'b0000, 4'b0000, 4'b0000);
      check("stall_valid", 32'(bus.cdb_valid), 32'd1);
      check("stall_src",   32'(bus.cdb_src), 32'b1000);
      check("stall_data",  bus.cdb_data, pdata[3]);
      check("stall_wait0", 32'(dut.wait_cnt[0]), 32'd1);
      check("stall_wait3", 32'(dut.wait_cnt[3]), 32'd0);
    end
    cycle(4'b1111, 1'b0, 4'b0001, 4'b0000, 4'b0000);
    check("post_stall_wait1", 32'(dut.wait_cnt[1]), 32'd2);
    cycle(4'b0000, 1'b0, 4'b0000, 4'b0000, 4'b0000);

    // Requester 1 left unserved for two cycles, then withdrawn.
    cycle(4'b0100, 1'b0, 4'b0100, 4'b0000, 4'b0000);
    cycle(4'b1010, 1'b0, 4'b1000, 4'b0000, 4'b0000);
    check("drop_wait1_a", 32'(dut.wait_cnt[1]), 32'd1);
    cycle(4'b0011, 1'b0, 4'b0001, 4'b0000, 4'b0000);
    check("drop_wait1_b", 32'(dut.wait_cnt[1]), 32'd2);
    cycle(4'b0000, 1'b0, 4'b0000, 4'b0000, 4'b0000);
    check("drop_wait1_c", 32'(dut.wait_cnt[1]), 32'd0);
    cycle(4'b0100, 1'b0, 4'b0100, 4'b0000, 4'b0000);

    // Reset between edges: grant of this cycle is discarded.
    apply_payload();
    bus.cdb_isr_request = 4'b1111;
    bus.cdb_stall       = 1'b0;
    #1;
    check("pre_rst_grant", 32'(bus.cdb_isr_grant), 32'b1000);
    #1 RST = 1'b1;
    #1;
    check("mid_rst_grant", 32'(bus.cdb_isr_grant), 32'h0);
    check("mid_rst_valid", 32'(bus.cdb_valid), 32'h0);
    check("mid_rst_src",   32'(bus.cdb_src), 32'h0);
    @(negedge CLK);
    RST = 1'b0;
    cycle(4'b0110, 1'b0, 4'b0010, 4'b0000, 4'b0000);

    // Aging instance (MAX_WAIT=2): requester 3 overtakes rr_ptr=2 once aged.
    cycle(4'b0000, 1'b0, 4'b0000, 4'b1001, 4'b0001);
    cycle(4'b0000, 1'b0, 4'b0000, 4'b1010, 4'b0010);
    check("aging_wait3", 32'(dut_a.wait_cnt[3]), 32'd2);
    cycle(4'b0000, 1'b0, 4'b0000, 4'b1100, 4'b1000);
    check("aging_wait3_clr", 32'(dut_a.wait_cnt[3]), 32'd0);
    cycle(4'b0000, 1'b0, 4'b0000, 4'b1100, 4'b0100);

    #2;
    check("sb_drained", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
